// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: register map, CTRL bits and
// the centre-mode counting direction.
package pwm_pkg;

    localparam logic [7:0] CTRL_OFS   = 8'h00;
    localparam logic [7:0] PERIOD_OFS = 8'h04;
    localparam logic [7:0] PRESC_OFS  = 8'h08;
    localparam logic [7:0] STATUS_OFS = 8'h0C;
    localparam logic [7:0] POL_OFS    = 8'h10;
    localparam logic [7:0] CHEN_OFS   = 8'h14;
    localparam logic [7:0] DUTY_BASE  = 8'h20;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CENTER = 1;
    localparam int CTRL_IE     = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [7:0] duty_addr(input int i);
        return DUTY_BASE + 8'(4 * i);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/centre period counter with its
// direction FSM, and the tick / period-boundary strobes.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CW = 16,
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          center_i,
    input  logic [PW-1:0] presc_i,
    input  logic [CW-1:0] period_i,
    output logic [CW-1:0] cnt_o,
    output logic          tick_o,
    output logic          boundary_o
);

    logic [PW-1:0] pre_q;
    logic [CW-1:0] cnt_q;
    dir_e          dir_q;

    logic [CW-1:0] last;
    logic          p_zero;
    logic          at_top;

    assign p_zero = (period_i == '0);
    assign last   = period_i - CW'(1);
    assign at_top = (cnt_q >= last);

    assign tick_o     = en_i && (pre_q == presc_i);
    assign boundary_o = tick_o && !p_zero &&
                        (center_i ? (dir_q == DIR_DOWN && cnt_q == '0) : at_top);
    assign cnt_o      = cnt_q;

    // Turnarounds hold the end value for one extra tick, so a centre period is 2P ticks.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            pre_q <= '0;
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            pre_q <= tick_o ? '0 : pre_q + PW'(1);
            if (tick_o) begin
                if (p_zero) begin
                    cnt_q <= '0;
                    dir_q <= DIR_UP;
                end else if (!center_i) begin
                    cnt_q <= at_top ? '0 : cnt_q + CW'(1);
                    dir_q <= DIR_UP;
                end else begin
                    case (dir_q)
                        DIR_UP: begin
                            if (at_top) dir_q <= DIR_DOWN;
                            else        cnt_q <= cnt_q + CW'(1);
                        end
                        DIR_DOWN: begin
                            if (cnt_q == '0) dir_q <= DIR_UP;
                            else             cnt_q <= cnt_q - CW'(1);
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: bus registers, shadow/active period and duty
// copies, per-channel compare and the period-wrap interrupt.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CW   = 16,
    parameter int PW   = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            bus_we_i,
    input  logic [31:0]     bus_addr_i,
    input  logic [31:0]     bus_wdata_i,
    output logic [31:0]     bus_rdata_o,
    output logic [N_CH-1:0] pwm_out_o,
    output logic            irq_o
);

    logic [2:0]                 ctrl_q;
    logic [CW-1:0]              per_sh_q, per_act_q;
    logic [PW-1:0]              presc_q;
    logic                       wrap_q;
    logic [N_CH-1:0]            pol_q, chen_q;
    logic [N_CH-1:0][CW-1:0]    duty_sh_q, duty_act_q;
    logic                       center_act_q;
    logic [N_CH-1:0]            pwm_out_q;
    logic                       irq_q;

    logic [7:0]      addr8;
    logic            en_rise, w1c, load;
    logic [CW-1:0]   cnt;
    logic            tick, boundary;
    logic [N_CH-1:0] pwm_d;

    assign addr8   = bus_addr_i[7:0];
    assign en_rise = bus_we_i && addr8 == CTRL_OFS && bus_wdata_i[CTRL_EN] && !ctrl_q[CTRL_EN];
    assign w1c     = bus_we_i && addr8 == STATUS_OFS && bus_wdata_i[0];
    assign load    = en_rise || boundary;

    pwm_timebase #(.CW(CW), .PW(PW)) u_tb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (ctrl_q[CTRL_EN]),
        .center_i   (center_act_q),
        .presc_i    (presc_q),
        .period_i   (per_act_q),
        .cnt_o      (cnt),
        .tick_o     (tick),
        .boundary_o (boundary)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign pwm_d[g] = (ctrl_q[CTRL_EN] && chen_q[g] && per_act_q != '0 &&
                           cnt < duty_act_q[g]) ^ pol_q[g];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q       <= '0;
            per_sh_q     <= '0;
            per_act_q    <= '0;
            presc_q      <= '0;
            wrap_q       <= 1'b0;
            pol_q        <= '0;
            chen_q       <= '0;
            duty_sh_q    <= '0;
            duty_act_q   <= '0;
            center_act_q <= 1'b0;
            pwm_out_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            // On enable the CENTER bit being written wins over the stale shadow.
            if (load) begin
                per_act_q    <= per_sh_q;
                duty_act_q   <= duty_sh_q;
                center_act_q <= en_rise ? bus_wdata_i[CTRL_CENTER] : ctrl_q[CTRL_CENTER];
            end
            if (boundary)  wrap_q <= 1'b1;
            else if (w1c)  wrap_q <= 1'b0;
            if (bus_we_i) begin
                case (addr8)
                    CTRL_OFS:   ctrl_q   <= bus_wdata_i[2:0];
                    PERIOD_OFS: per_sh_q <= bus_wdata_i[CW-1:0];
                    PRESC_OFS:  presc_q  <= bus_wdata_i[PW-1:0];
                    POL_OFS:    pol_q    <= bus_wdata_i[N_CH-1:0];
                    CHEN_OFS:   chen_q   <= bus_wdata_i[N_CH-1:0];
                    default: begin
                        for (int i = 0; i < N_CH; i++)
                            if (addr8 == duty_addr(i)) duty_sh_q[i] <= bus_wdata_i[CW-1:0];
                    end
                endcase
            end
            pwm_out_q <= pwm_d;
            irq_q     <= wrap_q & ctrl_q[CTRL_IE];
        end
    end

    always_comb begin
        bus_rdata_o = '0;
        case (addr8)
            CTRL_OFS:   bus_rdata_o[2:0]      = ctrl_q;
            PERIOD_OFS: bus_rdata_o[CW-1:0]   = per_sh_q;
            PRESC_OFS:  bus_rdata_o[PW-1:0]   = presc_q;
            STATUS_OFS: bus_rdata_o[0]        = wrap_q;
            POL_OFS:    bus_rdata_o[N_CH-1:0] = pol_q;
            CHEN_OFS:   bus_rdata_o[N_CH-1:0] = chen_q;
            default: begin
                for (int i = 0; i < N_CH; i++)
                    if (addr8 == duty_addr(i)) bus_rdata_o[CW-1:0] = duty_sh_q[i];
            end
        endcase
    end

    assign pwm_out_o = pwm_out_q;
    assign irq_o     = irq_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus_addr_i[31:8], bus_wdata_i, tick};

endmodule

// File: tb/tb_pwm_multi.sv
// Randomized bench for pwm_multi checked against a period-position model.
module tb_pwm_multi;

    localparam int N_CH = 4;
    localparam int CW   = 16;
    localparam int PW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            bus_we = 1'b0;
    logic [31:0]     bus_addr = '0;
    logic [31:0]     bus_wdata = '0;
    logic [31:0]     bus_rdata;
    logic [N_CH-1:0] pwm_out;
    logic            irq;

    int errors = 0;
    int checks = 0;
    int hi[N_CH];

    pwm_multi #(.N_CH(N_CH), .CW(CW), .PW(PW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_we_i    (bus_we),
        .bus_addr_i  (bus_addr),
        .bus_wdata_i (bus_wdata),
        .bus_rdata_o (bus_rdata),
        .pwm_out_o   (pwm_out),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: position k inside the current period (0..len-1).
    logic [2:0]      m_ctrl;
    int              m_per_sh, m_presc, m_aP, m_pre, m_k;
    bit              m_wrap, m_aC, m_irq;
    logic [N_CH-1:0] m_pol, m_chen, m_out;
    int              m_duty_sh[N_CH];
    int              m_aD[N_CH];

    always @(posedge clk) begin : model
        int len, c, a;
        bit en, tick, bnd, rise, irq_n;
        logic [N_CH-1:0] on;
        if (rst) begin
            m_ctrl = '0; m_per_sh = 0; m_presc = 0; m_aP = 0; m_pre = 0; m_k = 0;
            m_wrap = 0; m_aC = 0; m_irq = 0; m_pol = '0; m_chen = '0; m_out = '0;
            for (int i = 0; i < N_CH; i++) begin m_duty_sh[i] = 0; m_aD[i] = 0; end
        end else begin
            en    = m_ctrl[0];
            len   = m_aC ? 2 * m_aP : m_aP;
            c     = (m_aC && m_k >= m_aP) ? 2 * m_aP - 1 - m_k : m_k;
            for (int i = 0; i < N_CH; i++)
                on[i] = (en && m_chen[i] && m_aP != 0 && c < m_aD[i]) ^ m_pol[i];
            irq_n = m_wrap && m_ctrl[2];
            tick  = en && m_pre == m_presc;
            bnd   = tick && m_aP != 0 && m_k == len - 1;
            a     = int'(bus_addr[7:0]);
            rise  = bus_we && a == 0 && bus_wdata[0] && !en;
            if (!en) begin
                m_pre = 0; m_k = 0;
            end else begin
                m_pre = tick ? 0 : (m_pre + 1) % (1 << PW);
                if (tick && m_aP != 0) m_k = bnd ? 0 : m_k + 1;
            end
            if (bnd || rise) begin
                m_aP = m_per_sh;
                m_aD = m_duty_sh;
                m_aC = rise ? bus_wdata[1] : m_ctrl[1];
            end
            if (bnd) m_wrap = 1;
            else if (bus_we && a == 'h0C && bus_wdata[0]) m_wrap = 0;
            if (bus_we) begin
                case (a)
                    'h00: m_ctrl   = bus_wdata[2:0];
                    'h04: m_per_sh = int'(bus_wdata[CW-1:0]);
                    'h08: m_presc  = int'(bus_wdata[PW-1:0]);
                    'h10: m_pol    = bus_wdata[N_CH-1:0];
                    'h14: m_chen   = bus_wdata[N_CH-1:0];
                    default: if (a >= 'h20 && a < 'h20 + 4 * N_CH && a % 4 == 0)
                                 m_duty_sh[(a - 'h20) / 4] = int'(bus_wdata[CW-1:0]);
                endcase
            end
            m_out = on;
            m_irq = irq_n;
        end
    end

    function automatic logic [31:0] m_rd(input logic [31:0] addr);
        int a = int'(addr[7:0]);
        m_rd = '0;
        case (a)
            'h00: m_rd = 32'(m_ctrl);
            'h04: m_rd = m_per_sh;
            'h08: m_rd = m_presc;
            'h0C: m_rd = 32'(m_wrap);
            'h10: m_rd = 32'(m_pol);
            'h14: m_rd = 32'(m_chen);
            default: if (a >= 'h20 && a < 'h20 + 4 * N_CH && a % 4 == 0)
                         m_rd = m_duty_sh[(a - 'h20) / 4];
        endcase
    endfunction

    function automatic bit m_bnd_next();
        int len = m_aC ? 2 * m_aP : m_aP;
        return m_ctrl[0] && m_pre == m_presc && m_aP != 0 && m_k == len - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] tbl [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20,
                                  32'h24, 32'h28, 32'h2C, 32'h18, 32'h30, 32'h104};
        return tbl[$urandom_range(0, 12)];
    endfunction

    task automatic cyc();
        @(negedge clk);
        chk("pwm_out", 32'(pwm_out), 32'(m_out));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("rdata", bus_rdata, m_rd(bus_addr));
    endtask

    task automatic idle1();
        bus_addr = pick_addr();
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) idle1();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        cyc();
        bus_we = 1'b0; bus_addr = pick_addr();
    endtask

    task automatic count_hi(input int n);
        for (int i = 0; i < N_CH; i++) hi[i] = 0;
        repeat (n) begin
            idle1();
            for (int i = 0; i < N_CH; i++) hi[i] += int'(pwm_out[i]);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_addr = a;
        #1;
        chk(tag, bus_rdata, exp);
    endtask

    task automatic rand_wr();
        case ($urandom_range(0, 7))
            0: wr(32'h00, $urandom_range(0, 7));
            1: wr(32'h04, $urandom_range(0, 12));
            2: wr(32'h08, $urandom_range(0, 2));
            3: wr(32'h0C, 32'h1);
            4: wr(32'h10, $urandom_range(0, (1 << N_CH) - 1));
            5: wr(32'h14, $urandom_range(0, (1 << N_CH) - 1));
            default: wr(32'h20 + 4 * $urandom_range(0, N_CH - 1), $urandom_range(0, 14));
        endcase
    endtask

    task automatic mid_reset();
        rst = 1'b1; bus_we = 1'b0;
        cyc();
        chk("rst_mid_out", 32'(pwm_out), 32'h0);
        chk("rst_mid_irq", 32'(irq), 32'h0);
        rd_chk("rst_mid_ctrl", 32'h00, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        // Reset held two cycles
        cyc(); cyc();
        chk("rst_out", 32'(pwm_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 'h30; a += 4) rd_chk("rst_rd", a, 32'h0);
        rst = 1'b0;
        idle(2);

        // Edge mode
        wr(32'h08, 0); wr(32'h04, 20);
        wr(32'h20, 10); wr(32'h24, 0); wr(32'h28, 25); wr(32'h2C, 7);
        wr(32'h14, 32'h7); wr(32'h00, 32'h1);
        idle(5);
        count_hi(20);
        chk("edge_ch0_hi", hi[0], 10);
        chk("edge_ch1_hi", hi[1], 0);
        chk("edge_ch2_hi", hi[2], 20);

        // Shadowed duty then period written mid-period
        n = 0;
        while (m_k != 3 && n < 100) begin idle1(); n++; end
        chk("wait_k3", 32'(n < 100), 32'h1);
        wr(32'h20, 5);
        idle(20);
        count_hi(20);
        chk("shadow_duty_hi", hi[0], 5);
        idle(4);
        wr(32'h04, 12);
        idle(20);
        count_hi(12);
        chk("shadow_per_hi", hi[0], 5);

        // Centre mode
        wr(32'h00, 0); wr(32'h04, 10); wr(32'h20, 3);
        wr(32'h00, 32'h3);
        idle(25);
        count_hi(20);
        chk("center_hi", hi[0], 6);

        // Prescaler and interrupt
        wr(32'h00, 0); wr(32'h08, 3); wr(32'h04, 4); wr(32'h20, 2);
        wr(32'h0C, 1); wr(32'h00, 32'h5);
        idle(40);
        count_hi(16);
        chk("presc_hi", hi[0], 8);
        wr(32'h0C, 1);
        rd_chk("w1c_clear", 32'h0C, 32'h0);
        n = 0;
        while (!m_bnd_next() && n < 100) begin idle1(); n++; end
        chk("wait_bnd", 32'(n < 100), 32'h1);
        wr(32'h0C, 1);
        rd_chk("w1c_coinc", 32'h0C, 32'h1);
        idle(3);

        // Polarity / channel enable / zero period
        wr(32'h10, 32'h1); wr(32'h14, 32'h0);
        idle(3);
        count_hi(20);
        chk("pol_ch0_hi", hi[0], 20);
        wr(32'h04, 0);
        idle(20);
        wr(32'h0C, 1);
        idle(40);
        rd_chk("p0_nowrap", 32'h0C, 32'h0);
        chk("p0_out", 32'(pwm_out), 32'h1);
        wr(32'h10, 32'hF); wr(32'h14, 32'hF);
        idle(3);
        chk("p0_pol_all", 32'(pwm_out), 32'hF);

        // Randomized configurations with random mid-run writes
        for (int r = 0; r < 20; r++) begin
            wr(32'h00, 0);
            wr(32'h04, $urandom_range(1, 12));
            wr(32'h08, $urandom_range(0, 2));
            for (int i = 0; i < N_CH; i++) wr(32'h20 + 4 * i, $urandom_range(0, 14));
            wr(32'h10, $urandom_range(0, (1 << N_CH) - 1));
            wr(32'h14, $urandom_range(0, (1 << N_CH) - 1));
            wr(32'h00, {29'b0, 1'($urandom), 1'($urandom), 1'b1});
            repeat ($urandom_range(30, 80)) begin
                if ($urandom_range(0, 7) == 0) rand_wr();
                else idle1();
            end
            if (r == 10) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
